// File: rtl/quadrature_pkg.sv
// Shared types, default widths and a saturation helper for the quadrature velocity path.
package quadrature_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_PERIOD_CYCLES = 50000;
  localparam int DEF_VEL_WIDTH     = 16;
  localparam int DEF_AVG_LOG2      = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  // Clamp a signed value into the range of a 'width'-bit two's-complement number.
  function automatic logic signed [63:0] saturate_signed(input logic signed [63:0] value,
                                                         input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/cdc_stable_sampler.sv
// Two-flop sampler for a multi-bit asynchronous bus: a value is accepted only once
// two consecutive samples agree, so a word caught mid-transition is never passed on.
module cdc_stable_sampler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] s1;
  logic [DATA_WIDTH-1:0] s2;

  // NOTE: sequential state uses non-blocking assignments so s2 sees the previous s1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      dout <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s1 == s2) dout <= s2;
    end
  end

endmodule

// File: rtl/quadrature_velocity.sv
// Windowed position-delta measurement with a moving-average velocity output
// and a sticky saturation flag.
module quadrature_velocity
  import quadrature_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int VEL_WIDTH     = DEF_VEL_WIDTH,
  parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 ovf_clr,
  input  logic [DATA_WIDTH-1:0] cnt_in,
  output logic [DATA_WIDTH-1:0] pos_sync,
  output logic [VEL_WIDTH-1:0]  vel_out,
  output logic                 vel_valid,
  output logic                 overflow
);

  localparam int DEPTH   = 1 << AVG_LOG2;
  localparam int PTR_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W   = VEL_WIDTH + AVG_LOG2;
  localparam int TIMER_W = $clog2(PERIOD_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD_CYCLES - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(DEPTH - 1);

  state_t                      state;
  logic [TIMER_W-1:0]          timer;
  logic [DATA_WIDTH-1:0]       prev_pos;
  logic [PTR_W-1:0]            ptr;
  logic signed [VEL_WIDTH-1:0] history [DEPTH];
  logic signed [SUM_W-1:0]     sum;
  logic signed [SUM_W-1:0]     sum_next;
  logic [DATA_WIDTH-1:0]       diff;
  logic signed [63:0]          delta;
  logic signed [VEL_WIDTH-1:0] entry;
  logic                        tick;
  logic                        sat_hit;

  cdc_stable_sampler #(.DATA_WIDTH(DATA_WIDTH)) u_sampler (
    .clk  (clk),
    .rst  (rst),
    .din  (cnt_in),
    .dout (pos_sync)
  );

  // Modular subtraction reinterpreted as signed makes counter wrap transparent.
  always_comb begin
    tick     = (state != IDLE) && (timer == TIMER_LAST);
    diff     = pos_sync - prev_pos;
    delta    = 64'($signed(diff));
    entry    = VEL_WIDTH'(saturate_signed(delta, VEL_WIDTH));
    sat_hit  = (64'(entry) != delta);
    sum_next = sum + SUM_W'(entry) - SUM_W'(history[ptr]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      prev_pos  <= '0;
      ptr       <= '0;
      sum       <= '0;
      vel_out   <= '0;
      vel_valid <= 1'b0;
      overflow  <= 1'b0;
      // NOTE: the history ring is reset explicitly; the running sum is only valid if it starts at zero.
      for (int i = 0; i < DEPTH; i++) history[i] <= '0;
    end else begin
      vel_valid <= 1'b0;
      if (ovf_clr) overflow <= 1'b0;

      if (!enable) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        timer <= (state == IDLE || tick) ? '0 : timer + 1'b1;
        case (state)
          IDLE: begin
            state <= PRIME;
            ptr   <= '0;
            sum   <= '0;
            for (int i = 0; i < DEPTH; i++) history[i] <= '0;
          end
          PRIME: begin
            if (tick) begin
              prev_pos <= pos_sync;
              state    <= RUN;
            end
          end
          RUN: begin
            if (tick) begin
              prev_pos     <= pos_sync;
              history[ptr] <= entry;
              sum          <= sum_next;
              ptr          <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
              vel_out      <= VEL_WIDTH'(sum_next >>> AVG_LOG2);
              vel_valid    <= 1'b1;
              // Placed after the clear so a same-cycle saturation wins.
              if (sat_hit) overflow <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quadrature_velocity.sv
// Self-checking bench: randomized and directed windows against a queue-based velocity model.
module tb_quadrature_velocity;

  localparam int DW     = 32;
  localparam int VW     = 16;
  localparam int PERIOD = 8;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] cnt_in = '0;
  logic [DW-1:0] pos_sync;
  logic [VW-1:0] vel_out;
  logic          vel_valid;
  logic          overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_prev;
  int          m_hist[$];
  bit          m_ovf = 1'b0;
  int          m_vel = 0;

  quadrature_velocity #(
    .DATA_WIDTH    (DW),
    .PERIOD_CYCLES (PERIOD),
    .VEL_WIDTH     (VW),
    .AVG_LOG2      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ovf_clr   (ovf_clr),
    .cnt_in    (cnt_in),
    .pos_sync  (pos_sync),
    .vel_out   (vel_out),
    .vel_valid (vel_valid),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic model_prime(input logic [31:0] pos);
    m_prev = pos;
    m_hist = {0, 0, 0, 0};
  endtask

  // Average of the last DEPTH saturated window deltas, floored toward -inf.
  task automatic model_tick(input logic [31:0] pos, input bit clr_same_cycle);
    logic [31:0] d32;
    int d;
    int sum;
    bit sat;
    d32 = pos - m_prev;
    d   = $signed(d32);
    sat = 1'b0;
    if (d > 32767) begin d = 32767; sat = 1'b1; end
    else if (d < -32768) begin d = -32768; sat = 1'b1; end
    m_prev = pos;
    void'(m_hist.pop_front());
    m_hist.push_back(d);
    sum = 0;
    foreach (m_hist[i]) sum += m_hist[i];
    m_vel = (sum >= 0) ? sum / DEPTH : -((-sum + DEPTH - 1) / DEPTH);
    if (sat) m_ovf = 1'b1;
    else if (clr_same_cycle) m_ovf = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] pos);
    int bad;
    enable = 1'b0;
    cnt_in = pos;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    bad = 0;
    for (int i = 1; i <= PERIOD + 1; i++) begin
      @(negedge clk);
      if (vel_valid) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL prime_no_valid: got %0d strobes required 0", bad);
    end
    model_prime(pos);
  endtask

  // One measurement window; clr_at = 0 none, 7 = same cycle as tick, else mid-window.
  task automatic do_window(input logic [31:0] pos, input int clr_at, input string name);
    int at;
    int got;
    at = 0;
    cnt_in = pos;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (clr_at != 0 && clr_at != 7 && i == clr_at + 1) begin
        m_ovf = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_clean_clr: got overflow %0b required 0", name, overflow);
        end
      end
      ovf_clr = (i == clr_at);
      if (vel_valid) begin
        at = i;
        break;
      end
    end
    ovf_clr = 1'b0;
    model_tick(pos, clr_at == 7);
    tests_run++;
    if (at !== PERIOD) begin
      tests_failed++;
      $display("FAIL %s_spacing: got valid after %0d clk required %0d", name, at, PERIOD);
    end
    got = $signed(vel_out);
    tests_run++;
    if (got !== m_vel) begin
      tests_failed++;
      $display("FAIL %s_vel: got %0d required %0d", name, got, m_vel);
    end
    tests_run++;
    if (overflow !== m_ovf) begin
      tests_failed++;
      $display("FAIL %s_overflow: got %0b required %0b", name, overflow, m_ovf);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pos_sync !== '0 || vel_out !== '0 || vel_valid !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: got pos=%0h vel=%0h valid=%0b ovf=%0b required all 0",
               pos_sync, vel_out, vel_valid, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cdc;
    logic [31:0] x;
    logic [31:0] v;
    logic [31:0] y;
    enable = 1'b0;
    x = 32'h1234_5678;
    cnt_in = x;
    repeat (5) @(negedge clk);
    tests_run++;
    if (pos_sync !== x) begin
      tests_failed++;
      $display("FAIL cdc_settle: got %0h required %0h", pos_sync, x);
    end
    v = x;
    for (int i = 0; i < 20; i++) begin
      v = v ^ ($urandom() | 32'h1);
      cnt_in = v;
      @(negedge clk);
      tests_run++;
      if (pos_sync !== x) begin
        tests_failed++;
        $display("FAIL cdc_hold_%0d: got %0h required %0h", i, pos_sync, x);
      end
    end
    y = v ^ ($urandom() | 32'h1);
    cnt_in = y;
    repeat (2) @(negedge clk);
    tests_run++;
    if (pos_sync !== x) begin
      tests_failed++;
      $display("FAIL cdc_early: got %0h required %0h", pos_sync, x);
    end
    @(negedge clk);
    tests_run++;
    if (pos_sync !== y) begin
      tests_failed++;
      $display("FAIL cdc_lag3: got %0h required %0h", pos_sync, y);
    end
  endtask

  task automatic test_constant;
    start_run(32'd100);
    for (int i = 0; i < 10; i++) do_window(32'd100, 0, "const");
  endtask

  task automatic test_ramp;
    start_run(32'd1000);
    for (int k = 1; k <= 6; k++) do_window(32'(1000 + 3 * k), 0, "ramp_up");
    start_run(32'd2000);
    for (int k = 1; k <= 6; k++) do_window(32'(2000 - 3 * k), 0, "ramp_down");
  endtask

  task automatic test_wrap;
    start_run(32'hFFFF_FFFE);
    do_window(32'h0000_0001, 0, "wrap_fwd");
    do_window(32'h0000_0004, 0, "wrap_fwd");
    do_window(32'h0000_0007, 0, "wrap_fwd");
    start_run(32'h0000_0001);
    do_window(32'hFFFF_FFFE, 0, "wrap_rev");
    do_window(32'hFFFF_FFFB, 0, "wrap_rev");
    do_window(32'hFFFF_FFF8, 0, "wrap_rev");
  endtask

  task automatic test_saturation;
    start_run(32'd0);
    do_window(32'd40000, 0, "sat_pos");
    do_window(32'd80000, 7, "sat_clr_tie");
    do_window(32'd80010, 3, "sat_clean");
    do_window(32'd40010, 0, "sat_neg");
  endtask

  task automatic test_random;
    logic [31:0] pos;
    int step;
    pos = $urandom();
    start_run(pos);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 7) == 0) step = $urandom_range(0, 1) ? 45000 : -45000;
      else step = int'($urandom_range(0, 400)) - 200;
      pos = pos + 32'(step);
      do_window(pos, ($urandom_range(0, 5) == 0) ? 3 : 0, "random");
    end
  endtask

  task automatic test_enable_drop;
    int seen;
    int saved;
    int got;
    start_run(32'd300);
    do_window(32'd310, 0, "en_pre");
    do_window(32'd330, 0, "en_pre");
    saved = m_vel;
    cnt_in = 32'd400;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == PERIOD - 1) enable = 1'b0;
      if (vel_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL en_drop_valid: got %0d strobes required 0", seen);
    end
    got = $signed(vel_out);
    tests_run++;
    if (got !== saved) begin
      tests_failed++;
      $display("FAIL en_drop_hold: got %0d required %0d", got, saved);
    end
  endtask

  task automatic test_rst_mid_run;
    int at;
    start_run(32'd500);
    do_window(32'd40500, 0, "rst_pre");
    cnt_in = 32'd40600;
    repeat (PERIOD - 1) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (pos_sync !== '0 || vel_out !== '0 || vel_valid !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: got pos=%0h vel=%0h valid=%0b ovf=%0b required all 0",
               pos_sync, vel_out, vel_valid, overflow);
    end
    @(negedge clk);
    tests_run++;
    if (vel_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_suppress: got valid %0b required 0", vel_valid);
    end
    rst = 1'b0;
    m_ovf = 1'b0;
    at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (vel_valid) begin
        at = i;
        break;
      end
    end
    tests_run++;
    if (at !== 2 * PERIOD + 1) begin
      tests_failed++;
      $display("FAIL rst_restart_latency: got %0d clk required %0d", at, 2 * PERIOD + 1);
    end
    model_prime(32'd40600);
    model_tick(32'd40600, 1'b0);
    tests_run++;
    if ($signed(vel_out) !== m_vel || overflow !== m_ovf) begin
      tests_failed++;
      $display("FAIL rst_restart_out: got vel=%0d ovf=%0b required vel=%0d ovf=%0b",
               $signed(vel_out), overflow, m_vel, m_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_cdc();
    test_constant();
    test_ramp();
    test_wrap();
    test_saturation();
    test_random();
    test_enable_drop();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
